// File: rtl/fan_ctrl_pkg.sv
// rtl/fan_ctrl_pkg.sv - shared encodings for the fan front-panel input stage
//
// Contents:
//   fan_state_t : command FSM states IDLE / ARMED / HOLD
//   fan_cmd_t   : command encoding, bit order {down, up}
//   LOW / HIGH  : single-bit level constants
package fan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      HOLD  = 2'd2
   } fan_state_t;

   // {down, up}: stop is both bits set
   typedef enum logic [1:0] {
      CMD_NONE = 2'b00,
      CMD_UP   = 2'b01,
      CMD_DOWN = 2'b10,
      CMD_STOP = 2'b11
   } fan_cmd_t;

   localparam logic LOW  = 1'b0;
   localparam logic HIGH = 1'b1;

endpackage

// File: rtl/fan_button_interface_debounce.sv
// rtl/fan_button_interface_debounce.sv - per-button synchroniser, debouncer and press detector
//
// Module button_debounce
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles before the stable value flips (>= 2)
// Ports:
//   clk    in  : system clock
//   reset  in  : synchronous active-high reset
//   raw    in  : raw asynchronous button
//   stable out : debounced button level
//   press  out : one-cycle pulse on the stable 0->1 flip
module button_debounce
   import fan_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          flip;

   // The counter holds the number of differing cycles already seen, so the
   // DEBOUNCE_CYCLES-th differing cycle is the one where it reads N-1.
   assign flip  = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
   // Press is asserted in the same cycle the flip is decided, so the command
   // FSM sees it on the edge where stable rises.
   assign press = flip && sync2;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= LOW;
         sync2  <= LOW;
         stable <= LOW;
         cnt    <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (flip) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fan_button_interface.sv
// rtl/fan_button_interface.sv - two-button front panel to fan controller command strobe
//
// Optional feature macro: FAN_BTN_AUTOREPEAT_EN (auto-repeat of a held single command)
// Parameters:
//   DEBOUNCE_CYCLES : debounce length in cycles (>= 2)
//   COMBO_WINDOW    : cycles after a first press in which the other press forms a stop (>= 1)
//   REPEAT_CYCLES   : auto-repeat period, used only with FAN_BTN_AUTOREPEAT_EN (>= 2)
// Ports:
//   clk      in  : system clock
//   reset    in  : synchronous active-high reset
//   btn_up   in  : raw up button
//   btn_down in  : raw down button
//   update   out : one-cycle command strobe
//   up       out : up command, 0 unless update
//   down     out : down command, 0 unless update; up=down=1 is stop
module fan_button_interface
   import fan_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int COMBO_WINDOW    = 8,
   parameter int REPEAT_CYCLES   = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   output logic update,
   output logic up,
   output logic down
);

   localparam int WW = $clog2(COMBO_WINDOW + 1);

   // Elaboration-time parameter legality checks.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 2");
   end
   if (COMBO_WINDOW < 1) begin : g_bad_window
      $error("COMBO_WINDOW must be >= 1");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_repeat
      $error("REPEAT_CYCLES must be >= 2");
   end

   logic          stable_up;
   logic          stable_down;
   logic          press_up;
   logic          press_down;

   fan_state_t    state;
   logic [WW-1:0] win_cnt;
   logic [WW-1:0] win_next;
   logic          rec_down;
   logic          stop_pend;
   logic          other_press;

`ifdef FAN_BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   logic          rep_active;
   logic [RW-1:0] rep_cnt;
   logic          rep_held;
   assign rep_held = rec_down ? (stable_down && !stable_up)
                              : (stable_up && !stable_down);
`endif

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
      .clk    (clk),
      .reset  (reset),
      .raw    (btn_up),
      .stable (stable_up),
      .press  (press_up)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
      .clk    (clk),
      .reset  (reset),
      .raw    (btn_down),
      .stable (stable_down),
      .press  (press_down)
   );

   assign win_next    = win_cnt + 1'b1;
   assign other_press = rec_down ? press_up : press_down;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         win_cnt     <= '0;
         rec_down    <= LOW;
         stop_pend   <= LOW;
         update      <= LOW;
         {down, up}  <= CMD_NONE;
`ifdef FAN_BTN_AUTOREPEAT_EN
         rep_active  <= LOW;
         rep_cnt     <= '0;
`endif
      end else begin
         update     <= LOW;
         {down, up} <= CMD_NONE;
         stop_pend  <= LOW;

         // A stop is decided one edge and emitted on the next.
         if (stop_pend) begin
            update     <= HIGH;
            {down, up} <= CMD_STOP;
         end

         case (state)
            IDLE: begin
               if (press_up && press_down) begin
                  stop_pend <= HIGH;
                  state     <= HOLD;
               end else if (press_up || press_down) begin
                  rec_down <= press_down;
                  win_cnt  <= '0;
                  state    <= ARMED;
               end
            end

            ARMED: begin
               // The other press wins over a window expiring on the same edge,
               // since the counter is still below COMBO_WINDOW at that point.
               if (other_press) begin
                  stop_pend <= HIGH;
                  state     <= HOLD;
               end else if (win_next == WW'(COMBO_WINDOW)) begin
                  update     <= HIGH;
                  {down, up} <= rec_down ? CMD_DOWN : CMD_UP;
                  state      <= HOLD;
`ifdef FAN_BTN_AUTOREPEAT_EN
                  rep_active <= HIGH;
                  rep_cnt    <= '0;
`endif
               end else begin
                  win_cnt <= win_next;
               end
            end

            HOLD: begin
`ifdef FAN_BTN_AUTOREPEAT_EN
               // Repeat ends for good once the held button is released or the
               // other button joins; it is not re-armed within this HOLD.
               if (rep_active) begin
                  if (!rep_held) begin
                     rep_active <= LOW;
                  end else if (rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
                     update     <= HIGH;
                     {down, up} <= rec_down ? CMD_DOWN : CMD_UP;
                     rep_cnt    <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + 1'b1;
                  end
               end
`endif
               if (!stable_up && !stable_down) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fan_button_interface.sv
// tb/tb_fan_button_interface.sv - directed self-checking bench for fan_button_interface
module tb_fan_button_interface;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic update;
   logic up;
   logic down;

   int vectors = 0;
   int miscompares = 0;

   int         ev_k[$];
   logic [1:0] ev_cmd[$];
   int         bad_idle;

   always #5 clk = ~clk;

   fan_button_interface dut (
      .clk      (clk),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .update   (update),
      .up       (up),
      .down     (down)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      ev_k.delete();
      ev_cmd.delete();
      bad_idle = 0;
   endtask

   // Runs n cycles, logging every strobe with its cycle index (base+k) and
   // counting cycles where up/down are set without update.
   task automatic observe(input int n, input int base);
      for (int k = 1; k <= n; k++) begin
         tick();
         if (update === 1'b1) begin
            ev_k.push_back(base + k);
            ev_cmd.push_back({down, up});
         end else if (up !== 1'b0 || down !== 1'b0) begin
            bad_idle++;
         end
      end
   endtask

   task automatic release_all(input string name);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      clear_events();
      observe(40, 0);
      vectors++;
      if (ev_k.size() !== 0) begin
         miscompares++;
         $display("FAIL %s_release_strobes actual=%0d required=0", name, ev_k.size());
      end
   endtask

   // Checks that exactly one strobe occurred at cycle exp_k carrying exp_cmd.
   task automatic check_one(input string name, input int exp_k, input logic [1:0] exp_cmd);
      int         k;
      logic [1:0] c;
      k = (ev_k.size() > 0) ? ev_k[0] : -1;
      c = (ev_cmd.size() > 0) ? ev_cmd[0] : 2'bxx;
      vectors++;
      if (ev_k.size() !== 1) begin
         miscompares++;
         $display("FAIL %s_count actual=%0d required=1", name, ev_k.size());
      end
      vectors++;
      if (k !== exp_k) begin
         miscompares++;
         $display("FAIL %s_latency actual=%0d required=%0d", name, k, exp_k);
      end
      vectors++;
      if (c !== exp_cmd) begin
         miscompares++;
         $display("FAIL %s_cmd actual=%b required=%b", name, c, exp_cmd);
      end
      vectors++;
      if (bad_idle !== 0) begin
         miscompares++;
         $display("FAIL %s_idle_cmd actual=%0d required=0", name, bad_idle);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if ({update, up, down} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs actual=%b required=000", {update, up, down});
         end
      end
      reset = 1'b0;
      clear_events();
      observe(100, 0);
      vectors++;
      if (ev_k.size() !== 0) begin
         miscompares++;
         $display("FAIL reset_quiet_strobes actual=%0d required=0", ev_k.size());
      end
      vectors++;
      if (bad_idle !== 0) begin
         miscompares++;
         $display("FAIL reset_quiet_cmd actual=%0d required=0", bad_idle);
      end
   endtask

   task automatic test_single_up();
      clear_events();
      btn_up = 1'b1;
      observe(60, 0);
      check_one("single_up", 26, 2'b01);
      release_all("single_up");
   endtask

   task automatic test_single_down();
      clear_events();
      btn_down = 1'b1;
      observe(60, 0);
      check_one("single_down", 26, 2'b10);
      release_all("single_down");
   endtask

   task automatic test_bounce();
      clear_events();
      for (int p = 0; p < 10; p++) begin
         btn_up = (p % 2 == 0);
         observe(3, 0);
      end
      vectors++;
      if (ev_k.size() !== 0) begin
         miscompares++;
         $display("FAIL bounce_strobes actual=%0d required=0", ev_k.size());
      end
      clear_events();
      btn_up = 1'b1;
      observe(40, 0);
      check_one("bounce_settle", 26, 2'b01);
      release_all("bounce");
   endtask

   task automatic test_combo();
      clear_events();
      btn_up = 1'b1;
      observe(5, 0);
      btn_down = 1'b1;
      observe(35, 5);
      check_one("combo", 24, 2'b11);
      release_all("combo");
   endtask

   task automatic test_same_cycle();
      clear_events();
      btn_up   = 1'b1;
      btn_down = 1'b1;
      observe(40, 0);
      check_one("same_cycle", 19, 2'b11);
      release_all("same_cycle");
   endtask

   task automatic test_window_edge();
      clear_events();
      btn_up = 1'b1;
      observe(8, 0);
      btn_down = 1'b1;
      observe(32, 8);
      check_one("window_edge", 27, 2'b11);
      release_all("window_edge");
   endtask

   task automatic test_outside_window();
      clear_events();
      btn_up = 1'b1;
      observe(12, 0);
      btn_down = 1'b1;
      observe(48, 12);
      check_one("outside_window", 26, 2'b01);
      release_all("outside_window");
      clear_events();
      btn_up = 1'b1;
      observe(40, 0);
      check_one("repress_up", 26, 2'b01);
      release_all("repress_up");
   endtask

   task automatic test_reset_armed();
      clear_events();
      btn_up = 1'b1;
      observe(19, 0);
      vectors++;
      if (ev_k.size() !== 0) begin
         miscompares++;
         $display("FAIL armed_pre_reset_strobes actual=%0d required=0", ev_k.size());
      end
      reset = 1'b1;
      tick();
      vectors++;
      if ({update, up, down} !== 3'b000) begin
         miscompares++;
         $display("FAIL armed_reset_outputs actual=%b required=000", {update, up, down});
      end
      reset = 1'b0;
      clear_events();
      observe(40, 0);
      check_one("held_through_reset", 26, 2'b01);
      release_all("held_through_reset");
   endtask

   initial begin
      test_reset();
      test_single_up();
      test_single_down();
      test_bounce();
      test_combo();
      test_same_cycle();
      test_window_edge();
      test_outside_window();
      test_reset_armed();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
